// File: rtl/iiq_simple.sv
// Integer issue queue: collapsing, age-ordered, oldest-ready select with tag wakeup/capture.
// Optional statistics outputs enabled by defining IIQ_STATS_EN.
module iiq_simple #(
  parameter int unsigned N_ENTRIES     = 8,
  parameter int unsigned ROB_ID_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PAYLOAD_WIDTH = 96
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  output logic                           dispatch_ready,
  input  logic                           dispatch_valid,
  input  logic                           dispatch_src1_valid,
  input  logic                           dispatch_src2_valid,
  input  logic [ROB_ID_WIDTH-1:0]        dispatch_src1_rob_id,
  input  logic [ROB_ID_WIDTH-1:0]        dispatch_src2_rob_id,
  input  logic                           dispatch_src1_ready,
  input  logic                           dispatch_src2_ready,
  input  logic [DATA_WIDTH-1:0]          dispatch_src1_data,
  input  logic [DATA_WIDTH-1:0]          dispatch_src2_data,
  input  logic                           dispatch_dst_valid,
  input  logic [ROB_ID_WIDTH-1:0]        dispatch_rob_id,
  input  logic [PAYLOAD_WIDTH-1:0]       dispatch_payload,
  input  logic                           alu_issue_ready,
  output logic                           alu_issue_valid,
  output logic [DATA_WIDTH-1:0]          alu_issue_src1_data,
  output logic [DATA_WIDTH-1:0]          alu_issue_src2_data,
  output logic [ROB_ID_WIDTH-1:0]        alu_issue_rob_id,
  output logic                           alu_issue_dst_valid,
  output logic [PAYLOAD_WIDTH-1:0]       alu_issue_payload,
  output logic                           iiq_wakeup_valid,
  output logic [ROB_ID_WIDTH-1:0]        iiq_wakeup_rob_id,
  input  logic                           alu_broadcast_valid,
  input  logic [ROB_ID_WIDTH-1:0]        alu_broadcast_rob_id,
  input  logic [DATA_WIDTH-1:0]          alu_broadcast_reg_data,
  input  logic                           ld_broadcast_valid,
  input  logic [ROB_ID_WIDTH-1:0]        ld_broadcast_rob_id,
`ifdef IIQ_STATS_EN
  input  logic [DATA_WIDTH-1:0]          ld_broadcast_reg_data,
  output logic [$clog2(N_ENTRIES+1)-1:0] stat_occupancy,
  output logic [31:0]                    stat_full_stall_cnt
`else
  input  logic [DATA_WIDTH-1:0]          ld_broadcast_reg_data
`endif
);

  localparam int unsigned IdxW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int unsigned CntW = $clog2(N_ENTRIES + 1);

  typedef struct packed {
    logic                    valid;
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
  } src_t;

  typedef struct packed {
    logic                     valid;
    src_t                     src1;
    src_t                     src2;
    logic                     dst_valid;
    logic [ROB_ID_WIDTH-1:0]  rob_id;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } entry_t;

  entry_t          ent_q [N_ENTRIES];
  entry_t          ent_d [N_ENTRIES];
  entry_t          woke  [N_ENTRIES];
  logic [CntW-1:0] count_q, count_d;

  logic [N_ENTRIES-1:0] rdy;
  logic                 any_rdy;
  logic [IdxW-1:0]      sel_idx;
  entry_t               sel_ent;
  entry_t               new_ent;
  logic                 fire;
  logic                 accept;
  logic [CntW-1:0]      wr_cnt;

  // ALU broadcast takes priority over load for data; issue wakeup only sets ready.
  function automatic src_t wake_src(input src_t s,
                                    input logic wk_v, input logic [ROB_ID_WIDTH-1:0] wk_id,
                                    input logic alu_v, input logic [ROB_ID_WIDTH-1:0] alu_id,
                                    input logic [DATA_WIDTH-1:0] alu_d,
                                    input logic ld_v, input logic [ROB_ID_WIDTH-1:0] ld_id,
                                    input logic [DATA_WIDTH-1:0] ld_d);
    src_t r;
    r = s;
    if (s.valid && !s.ready) begin
      if (alu_v && (alu_id == s.rob_id)) begin
        r.ready = 1'b1;
        r.data  = alu_d;
      end else if (ld_v && (ld_id == s.rob_id)) begin
        r.ready = 1'b1;
        r.data  = ld_d;
      end
      if (wk_v && (wk_id == s.rob_id)) r.ready = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    rdy     = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      rdy[i] = ent_q[i].valid & (~ent_q[i].src1.valid | ent_q[i].src1.ready)
                              & (~ent_q[i].src2.valid | ent_q[i].src2.ready);
    end
    for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
      if (rdy[i]) sel_idx = IdxW'(i);
    end
    any_rdy = |rdy;
    sel_ent = any_rdy ? ent_q[sel_idx] : '0;
  end

  assign alu_issue_valid     = any_rdy & ~flush;
  assign alu_issue_src1_data = sel_ent.src1.data;
  assign alu_issue_src2_data = sel_ent.src2.data;
  assign alu_issue_rob_id    = sel_ent.rob_id;
  assign alu_issue_dst_valid = sel_ent.dst_valid;
  assign alu_issue_payload   = sel_ent.payload;

  assign fire              = alu_issue_valid & alu_issue_ready;
  assign iiq_wakeup_valid  = fire & sel_ent.dst_valid;
  assign iiq_wakeup_rob_id = sel_ent.rob_id;

  assign dispatch_ready = (count_q < CntW'(N_ENTRIES));
  assign accept         = dispatch_valid & dispatch_ready & ~flush;
  assign wr_cnt         = count_q - CntW'(fire);

  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.src1      = '{valid: dispatch_src1_valid, rob_id: dispatch_src1_rob_id,
                          ready: dispatch_src1_ready, data: dispatch_src1_data};
    new_ent.src2      = '{valid: dispatch_src2_valid, rob_id: dispatch_src2_rob_id,
                          ready: dispatch_src2_ready, data: dispatch_src2_data};
    new_ent.dst_valid = dispatch_dst_valid;
    new_ent.rob_id    = dispatch_rob_id;
    new_ent.payload   = dispatch_payload;
    new_ent.src1 = wake_src(new_ent.src1, iiq_wakeup_valid, iiq_wakeup_rob_id,
                            alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                            ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
    new_ent.src2 = wake_src(new_ent.src2, iiq_wakeup_valid, iiq_wakeup_rob_id,
                            alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                            ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);

    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      woke[i]      = ent_q[i];
      woke[i].src1 = wake_src(ent_q[i].src1, iiq_wakeup_valid, iiq_wakeup_rob_id,
                              alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                              ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
      woke[i].src2 = wake_src(ent_q[i].src2, iiq_wakeup_valid, iiq_wakeup_rob_id,
                              alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
                              ld_broadcast_valid, ld_broadcast_rob_id, ld_broadcast_reg_data);
    end

    ent_d = woke;
    // Collapse over the issued slot; the top slot is always vacated on issue.
    if (fire) begin
      for (int unsigned i = 0; i < N_ENTRIES - 1; i++) begin
        if (IdxW'(i) >= sel_idx) ent_d[i] = woke[i+1];
      end
      ent_d[N_ENTRIES-1] = '0;
    end
    if (accept) ent_d[wr_cnt[IdxW-1:0]] = new_ent;

    count_d = count_q + CntW'(accept) - CntW'(fire);

    if (flush) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) ent_d[i] = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < N_ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < N_ENTRIES; i++) ent_q[i] <= ent_d[i];
    end
  end

`ifdef IIQ_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (dispatch_valid && !dispatch_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_occupancy      = count_q;
  assign stat_full_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_iiq_simple.sv
// Directed self-checking bench for iiq_simple; stats checks compile in with IIQ_STATS_EN.
module tb_iiq_simple;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        dispatch_ready, dispatch_valid;
  logic        dispatch_src1_valid, dispatch_src2_valid;
  logic [3:0]  dispatch_src1_rob_id, dispatch_src2_rob_id;
  logic        dispatch_src1_ready, dispatch_src2_ready;
  logic [31:0] dispatch_src1_data, dispatch_src2_data;
  logic        dispatch_dst_valid;
  logic [3:0]  dispatch_rob_id;
  logic [95:0] dispatch_payload;
  logic        alu_issue_ready, alu_issue_valid;
  logic [31:0] alu_issue_src1_data, alu_issue_src2_data;
  logic [3:0]  alu_issue_rob_id;
  logic        alu_issue_dst_valid;
  logic [95:0] alu_issue_payload;
  logic        iiq_wakeup_valid;
  logic [3:0]  iiq_wakeup_rob_id;
  logic        alu_broadcast_valid;
  logic [3:0]  alu_broadcast_rob_id;
  logic [31:0] alu_broadcast_reg_data;
  logic        ld_broadcast_valid;
  logic [3:0]  ld_broadcast_rob_id;
  logic [31:0] ld_broadcast_reg_data;
`ifdef IIQ_STATS_EN
  logic [3:0]  stat_occupancy;
  logic [31:0] stat_full_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iiq_simple dut (
    .clk                    (clk),
    .rst                    (rst),
    .flush                  (flush),
    .dispatch_ready         (dispatch_ready),
    .dispatch_valid         (dispatch_valid),
    .dispatch_src1_valid    (dispatch_src1_valid),
    .dispatch_src2_valid    (dispatch_src2_valid),
    .dispatch_src1_rob_id   (dispatch_src1_rob_id),
    .dispatch_src2_rob_id   (dispatch_src2_rob_id),
    .dispatch_src1_ready    (dispatch_src1_ready),
    .dispatch_src2_ready    (dispatch_src2_ready),
    .dispatch_src1_data     (dispatch_src1_data),
    .dispatch_src2_data     (dispatch_src2_data),
    .dispatch_dst_valid     (dispatch_dst_valid),
    .dispatch_rob_id        (dispatch_rob_id),
    .dispatch_payload       (dispatch_payload),
    .alu_issue_ready        (alu_issue_ready),
    .alu_issue_valid        (alu_issue_valid),
    .alu_issue_src1_data    (alu_issue_src1_data),
    .alu_issue_src2_data    (alu_issue_src2_data),
    .alu_issue_rob_id       (alu_issue_rob_id),
    .alu_issue_dst_valid    (alu_issue_dst_valid),
    .alu_issue_payload      (alu_issue_payload),
    .iiq_wakeup_valid       (iiq_wakeup_valid),
    .iiq_wakeup_rob_id      (iiq_wakeup_rob_id),
    .alu_broadcast_valid    (alu_broadcast_valid),
    .alu_broadcast_rob_id   (alu_broadcast_rob_id),
    .alu_broadcast_reg_data (alu_broadcast_reg_data),
    .ld_broadcast_valid     (ld_broadcast_valid),
    .ld_broadcast_rob_id    (ld_broadcast_rob_id),
`ifdef IIQ_STATS_EN
    .ld_broadcast_reg_data  (ld_broadcast_reg_data),
    .stat_occupancy         (stat_occupancy),
    .stat_full_stall_cnt    (stat_full_stall_cnt)
`else
    .ld_broadcast_reg_data  (ld_broadcast_reg_data)
`endif
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush                  = 1'b0;
    dispatch_valid         = 1'b0;
    dispatch_src1_valid    = 1'b0;
    dispatch_src2_valid    = 1'b0;
    dispatch_src1_rob_id   = '0;
    dispatch_src2_rob_id   = '0;
    dispatch_src1_ready    = 1'b0;
    dispatch_src2_ready    = 1'b0;
    dispatch_src1_data     = '0;
    dispatch_src2_data     = '0;
    dispatch_dst_valid     = 1'b0;
    dispatch_rob_id        = '0;
    dispatch_payload       = '0;
    alu_broadcast_valid    = 1'b0;
    alu_broadcast_rob_id   = '0;
    alu_broadcast_reg_data = '0;
    ld_broadcast_valid     = 1'b0;
    ld_broadcast_rob_id    = '0;
    ld_broadcast_reg_data  = '0;
  endtask

  task automatic disp(input logic [3:0] rob,
                      input logic s1v, input logic [3:0] s1id, input logic s1r,
                      input logic [31:0] s1d,
                      input logic s2v, input logic [3:0] s2id, input logic s2r,
                      input logic [31:0] s2d, input logic dstv);
    dispatch_valid       = 1'b1;
    dispatch_rob_id      = rob;
    dispatch_src1_valid  = s1v;
    dispatch_src1_rob_id = s1id;
    dispatch_src1_ready  = s1r;
    dispatch_src1_data   = s1d;
    dispatch_src2_valid  = s2v;
    dispatch_src2_rob_id = s2id;
    dispatch_src2_ready  = s2r;
    dispatch_src2_data   = s2d;
    dispatch_dst_valid   = dstv;
    dispatch_payload     = {64'hCAFE_F00D_1234_5678, 28'h0, rob};
  endtask

  task automatic alu_bc(input logic [3:0] tag, input logic [31:0] d);
    alu_broadcast_valid    = 1'b1;
    alu_broadcast_rob_id   = tag;
    alu_broadcast_reg_data = d;
  endtask

  initial begin
    clr();
    alu_issue_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_dispatch_ready", 128'(dispatch_ready), 128'(1));
    check_eq("rst_issue_valid", 128'(alu_issue_valid), 128'(0));
    check_eq("rst_wakeup_valid", 128'(iiq_wakeup_valid), 128'(0));
    check_eq("rst_count", 128'(dut.count_q), 128'(0));

    // Ready dispatch issues the following cycle with wakeup.
    alu_issue_ready = 1'b1;
    disp(4'd3, 1'b1, 4'd0, 1'b1, 32'd5, 1'b1, 4'd0, 1'b1, 32'd7, 1'b1);
    #1;
    check_eq("s1_empty_no_issue", 128'(alu_issue_valid), 128'(0));
    tick();
    clr();
    #1;
    check_eq("s1_valid", 128'(alu_issue_valid), 128'(1));
    check_eq("s1_rob", 128'(alu_issue_rob_id), 128'(3));
    check_eq("s1_src1", 128'(alu_issue_src1_data), 128'(5));
    check_eq("s1_src2", 128'(alu_issue_src2_data), 128'(7));
    check_eq("s1_dst", 128'(alu_issue_dst_valid), 128'(1));
    check_eq("s1_payload", 128'(alu_issue_payload), 128'({64'hCAFE_F00D_1234_5678, 32'h3}));
    check_eq("s1_wk_valid", 128'(iiq_wakeup_valid), 128'(1));
    check_eq("s1_wk_rob", 128'(iiq_wakeup_rob_id), 128'(3));
    tick();
    check_eq("s1_count0", 128'(dut.count_q), 128'(0));
    check_eq("s1_idle", 128'(alu_issue_valid), 128'(0));

    // Dependency resolved by ALU broadcast with data capture.
    disp(4'd1, 1'b1, 4'd9, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
    tick();
    clr();
    alu_bc(4'd9, 32'h55);
    #1;
    check_eq("s2_wait", 128'(alu_issue_valid), 128'(0));
    tick();
    clr();
    #1;
    check_eq("s2_valid", 128'(alu_issue_valid), 128'(1));
    check_eq("s2_rob", 128'(alu_issue_rob_id), 128'(1));
    check_eq("s2_src1", 128'(alu_issue_src1_data), 128'(32'h55));
    tick();

    // Age order: younger ready entry passes an older waiting one.
    disp(4'd4, 1'b1, 4'd10, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
    tick();
    disp(4'd5, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
    tick();
    clr();
    alu_bc(4'd10, 32'h77);
    #1;
    check_eq("s3_first_rob", 128'(alu_issue_rob_id), 128'(5));
    tick();
    clr();
    #1;
    check_eq("s3_idx0_rob", 128'(dut.ent_q[0].rob_id), 128'(4));
    check_eq("s3_count", 128'(dut.count_q), 128'(1));
    check_eq("s3_second_rob", 128'(alu_issue_rob_id), 128'(4));
    check_eq("s3_second_src1", 128'(alu_issue_src1_data), 128'(32'h77));
    tick();
    check_eq("s3_count0", 128'(dut.count_q), 128'(0));

    // Fill to full; held dispatch stalls.
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 1'b1, (i == 0) ? 4'd14 : ((i == 1) ? 4'd13 : 4'd15), 1'b0, 32'd0,
           1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
      tick();
    end
    clr();
    #1;
    check_eq("s4_full_ready", 128'(dispatch_ready), 128'(0));
    check_eq("s4_full_count", 128'(dut.count_q), 128'(8));
    disp(4'd9, 1'b1, 4'd15, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
    repeat (3) tick();
    check_eq("s4_held_count", 128'(dut.count_q), 128'(8));
`ifdef IIQ_STATS_EN
    check_eq("s4_stall3", 128'(stat_full_stall_cnt), 128'(3));
`endif
    alu_bc(4'd14, 32'hE);
    tick();
    alu_broadcast_valid = 1'b0;
    #1;
    check_eq("s4_fire_valid", 128'(alu_issue_valid), 128'(1));
    check_eq("s4_fire_rob", 128'(alu_issue_rob_id), 128'(0));
    check_eq("s4_full_while_fire", 128'(dispatch_ready), 128'(0));
    tick();
    clr();
    #1;
    check_eq("s4_count7", 128'(dut.count_q), 128'(7));
    check_eq("s4_ready_again", 128'(dispatch_ready), 128'(1));
`ifdef IIQ_STATS_EN
    check_eq("s4_stall5", 128'(stat_full_stall_cnt), 128'(5));
    check_eq("s4_occ", 128'(stat_occupancy), 128'(7));
`endif

    // Count 7: issue and accept together.
    alu_bc(4'd13, 32'hD);
    tick();
    clr();
    disp(4'd8, 1'b1, 4'd15, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
    #1;
    check_eq("s5_fire_rob", 128'(alu_issue_rob_id), 128'(1));
    tick();
    clr();
    #1;
    check_eq("s5_count7", 128'(dut.count_q), 128'(7));
    check_eq("s5_idx6_rob", 128'(dut.ent_q[6].rob_id), 128'(8));
    check_eq("s5_idx6_valid", 128'(dut.ent_q[6].valid), 128'(1));
    check_eq("s5_idx0_rob", 128'(dut.ent_q[0].rob_id), 128'(2));

    // Flush with one ready entry.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    alu_issue_ready = 1'b0;
`ifdef IIQ_STATS_EN
    #1;
    check_eq("s6_stall_rst", 128'(stat_full_stall_cnt), 128'(0));
`endif
    for (int i = 1; i <= 3; i++) begin
      disp(4'(i), 1'b1, 4'd12, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
      tick();
    end
    disp(4'd4, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
    tick();
    clr();
    alu_issue_ready = 1'b1;
    disp(4'd9, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
    flush = 1'b1;
    #1;
    check_eq("s6_pre_count", 128'(dut.count_q), 128'(4));
    check_eq("s6_flush_issue", 128'(alu_issue_valid), 128'(0));
    check_eq("s6_flush_wk", 128'(iiq_wakeup_valid), 128'(0));
    tick();
    clr();
    #1;
    check_eq("s6_count0", 128'(dut.count_q), 128'(0));
    check_eq("s6_dispatch_ready", 128'(dispatch_ready), 128'(1));
    alu_bc(4'd12, 32'h12);
    tick();
    clr();
    #1;
    check_eq("s6_no_ghost", 128'(alu_issue_valid), 128'(0));

    // Load broadcast at dispatch time; ALU beats load on same tag.
    disp(4'd6, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1, 4'd11, 1'b0, 32'd0, 1'b1);
    ld_broadcast_valid    = 1'b1;
    ld_broadcast_rob_id   = 4'd11;
    ld_broadcast_reg_data = 32'h1234;
    tick();
    clr();
    #1;
    check_eq("s7_ld_rob", 128'(alu_issue_rob_id), 128'(6));
    check_eq("s7_ld_src2", 128'(alu_issue_src2_data), 128'(32'h1234));
    tick();
    disp(4'd7, 1'b1, 4'd9, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    tick();
    clr();
    alu_bc(4'd9, 32'hA);
    ld_broadcast_valid    = 1'b1;
    ld_broadcast_rob_id   = 4'd9;
    ld_broadcast_reg_data = 32'hB;
    tick();
    clr();
    #1;
    check_eq("s7_prio_rob", 128'(alu_issue_rob_id), 128'(7));
    check_eq("s7_prio_src1", 128'(alu_issue_src1_data), 128'(32'hA));
    check_eq("s7_nodst_wk", 128'(iiq_wakeup_valid), 128'(0));
    tick();

    // Issue wakeup and ALU broadcast to different tags in one cycle.
    alu_issue_ready = 1'b0;
    disp(4'd2, 1'b1, 4'd3, 1'b0, 32'd0, 1'b1, 4'd4, 1'b0, 32'd0, 1'b1);
    tick();
    disp(4'd3, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b1);
    tick();
    clr();
    alu_issue_ready = 1'b1;
    alu_bc(4'd4, 32'h44);
    #1;
    check_eq("s8_first_rob", 128'(alu_issue_rob_id), 128'(3));
    check_eq("s8_wk_rob", 128'(iiq_wakeup_rob_id), 128'(3));
    check_eq("s8_wk_valid", 128'(iiq_wakeup_valid), 128'(1));
    tick();
    clr();
    #1;
    check_eq("s8_dep_valid", 128'(alu_issue_valid), 128'(1));
    check_eq("s8_dep_rob", 128'(alu_issue_rob_id), 128'(2));
    check_eq("s8_dep_src2", 128'(alu_issue_src2_data), 128'(32'h44));
    tick();
    check_eq("s8_count0", 128'(dut.count_q), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iiq_simple.md
Name: iiq_simple

Overview:
- Integer issue queue, directly downstream of the dispatch stage.
- Accepts renamed integer instructions from dispatch and holds them until their source operands are ready. Operands become ready via the issue wakeup and the ALU/load broadcasts.
- Each cycle, selects the oldest ready entry and issues it to the ALU.
- Drives the issue-time wakeup (rob id) back to dispatch and ROB.

Parameters:
N_ENTRIES, 8, queue depth (>=2)
ROB_ID_WIDTH, 4, ROB tag width
DATA_WIDTH, 32, register data width
PAYLOAD_WIDTH, 96, opaque payload passed through untouched: imm, pc, funct3, type flags, branch prediction

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
flush  in  1  fetch redirect; discard all entries
dispatch_ready  out  1  queue can accept an entry
dispatch_valid  in  1  dispatch presents an entry
dispatch_src1_valid / dispatch_src2_valid  in  1 each  source exists
dispatch_src1_rob_id / dispatch_src2_rob_id  in  ROB_ID_WIDTH each  source tag
dispatch_src1_ready / dispatch_src2_ready  in  1 each  source already ready
dispatch_src1_data / dispatch_src2_data  in  DATA_WIDTH each  source value (meaningful if ready)
dispatch_dst_valid  in  1  instruction writes rd
dispatch_rob_id  in  ROB_ID_WIDTH  instruction tag
dispatch_payload  in  PAYLOAD_WIDTH  opaque fields
alu_issue_ready  in  1  ALU accepts
alu_issue_valid  out  1  issue slot valid
alu_issue_src1_data / alu_issue_src2_data  out  DATA_WIDTH each  captured operands
alu_issue_rob_id  out  ROB_ID_WIDTH  issued tag
alu_issue_dst_valid  out  1  issued instr writes rd
alu_issue_payload  out  PAYLOAD_WIDTH  issued payload
iiq_wakeup_valid  out  1  issue fired with dst_valid
iiq_wakeup_rob_id  out  ROB_ID_WIDTH  tag being woken
alu_broadcast_valid  in  1  ALU result valid
alu_broadcast_rob_id  in  ROB_ID_WIDTH  ALU result tag
alu_broadcast_reg_data  in  DATA_WIDTH  ALU result
ld_broadcast_valid  in  1  load result valid
ld_broadcast_rob_id  in  ROB_ID_WIDTH  load tag
ld_broadcast_reg_data  in  DATA_WIDTH  load data

Behaviour:
- Storage is a collapsing queue, entries 0..N_ENTRIES-1. Entry 0 is the oldest; valid entries are contiguous from 0.
- Per-entry state: valid, src1/src2 {valid, rob_id, ready, data}, dst_valid, rob_id, payload.
- Reset (rst=1 at posedge): all valid=0, count=0. Outputs the cycle after reset: dispatch_ready=1, alu_issue_valid=0, iiq_wakeup_valid=0.
- Entry ready = valid & (~src1_valid | src1_ready) & (~src2_valid | src2_ready).
- Select is combinational: the lowest-index ready entry.
  - alu_issue_valid = any ready & ~flush.
  - alu_issue_* = that entry's fields. Output is 0 when no entry is ready.
- Issue fire = alu_issue_valid & alu_issue_ready. On fire:
  - the selected entry is removed;
  - higher entries shift down by one, keeping age order.
- iiq_wakeup_valid = fire & selected dst_valid; iiq_wakeup_rob_id = selected rob_id. Both combinational, same cycle as fire.
- dispatch_ready = (count < N_ENTRIES). It does not depend on alu_issue_ready (no combinational path).
- Dispatch accept = dispatch_valid & dispatch_ready & ~flush. The entry is written at index count, or count-1 if a fire happens the same cycle. Count += accept - fire.
- Tag match, applied every cycle to every valid resident source and to the entry being written:
  - iiq_wakeup match: sets ready.
  - alu_broadcast match: sets ready and captures data.
  - ld_broadcast match: sets ready and captures data.
  - Matches apply only when src valid and the source is not already ready. Updates are visible next cycle.
- Same-cycle iiq_wakeup and alu_broadcast to different tags: both apply.
- alu_broadcast and ld_broadcast to the same tag cannot occur; if they do, ALU wins.
- Operand woken by iiq_wakeup only: its data arrives one cycle later on alu_broadcast. A dependant issued in the intervening cycle carries stale data; the ALU input bypass covers it (ALU responsibility).
- An entry issued in cycle t is never re-matched.
- Full: dispatch_ready=0 even if a fire occurs this cycle. Empty: alu_issue_valid=0.
- flush=1: alu_issue_valid and iiq_wakeup_valid forced to 0 that cycle, dispatch ignored. Next cycle: all valid=0, count=0.
- rst mid-operation behaves as flush, with the same post-reset output values.

Optional Feature:
- Macro: IIQ_STATS_EN.
- Defined, the block adds outputs:
  - stat_occupancy, $clog2(N_ENTRIES+1) bits: equals count;
  - stat_full_stall_cnt, 32 bits: increments, saturating, each cycle dispatch_valid=1 & dispatch_ready=0.
  - Both cleared by rst. stat_full_stall_cnt is not cleared by flush.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Ready dispatch: rob_id=3, both src ready, data 5/7, dst_valid=1, alu_issue_ready=1 -> next cycle alu_issue_valid=1, rob_id=3, src data 5/7, iiq_wakeup_valid=1 with rob_id=3; count back to 0.
- Dependency: entry A rob 1 waiting on src1 tag 9; alu_broadcast tag 9 data 0x55 -> A issues the next cycle with src1_data=0x55.
- Age order: entries rob 4 (waiting) then rob 5 (ready); tag for rob 4's source broadcast -> rob 5 issues first, then rob 4. Entries remain compacted (index 0 = rob 4 after rob 5 leaves).
- Full: 8 dispatches with unready sources -> dispatch_ready=0. A further dispatch_valid is held; with IIQ_STATS_EN, stat_full_stall_cnt counts those cycles. Waking one entry and issuing it -> dispatch_ready=1 the following cycle.
- Simultaneous events: full queue issuing and dispatch_valid in the same cycle -> no accept. Count 7 issuing and accepting in the same cycle -> count stays 7, new entry at index 6.
- Flush: 4 entries, one ready, flush=1 -> alu_issue_valid=0 that cycle; next cycle count=0, dispatch_ready=1. Broadcast of an old tag afterward causes no issue.
